mca_sequencer: RTL and testbench

//  Sequences the multi-cycle adder tree of the FIR estimator (add/sub stage, partial-sum stage, final stage).
//  - Generates the periodic start strobe that restarts all adder stages every NUM_ADDITIONS cycles.
//  - Admits one H/S frame per epoch from the upstream buffer, tracks frames in flight through the tree.
//  - Captures each finished sample into an output valid/ready register, flagging overruns.

---
 rtl/mca_sequencer.sv | 69 ++++++
 tb/tb_mca_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mca_sequencer.sv
// mca_sequencer: epoch start strobe, one-frame-per-epoch admission and sample capture for the multi-cycle adder tree
module mca_sequencer #(
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int NUM_ADDITIONS = 16,
  parameter int NUM_STAGES = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable,
  input  logic                         frame_valid,
  output logic                         frame_ready,
  output logic                         mca_start,
  input  logic [WIDTH_COEFFICIENT-1:0] sample_in,
  output logic [WIDTH_COEFFICIENT-1:0] sample_out,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         overrun,
  input  logic                         clear_overrun,
  output logic                         busy
);
  localparam int EW = $clog2(NUM_ADDITIONS);
  localparam logic [EW-1:0] LAST = EW'(NUM_ADDITIONS - 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic [EW-1:0] epoch, epoch_next;
  logic [NUM_STAGES-1:0] tok, tok_next;
  logic admitted, capture, overrun_set;
  always_comb begin
    busy = state != IDLE;
    mca_start = busy && epoch == '0;
    frame_ready = state == RUN && epoch == '0;
    admitted = frame_valid && frame_ready;
    tok_next = {tok[NUM_STAGES-2:0], admitted};
    capture = mca_start && tok[NUM_STAGES-1];
    overrun_set = capture && sample_valid && !sample_ready;
    epoch_next = epoch == LAST ? '0 : epoch + EW'(1);
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      epoch <= '0;
      tok <= '0;
    end else begin
      if (mca_start) tok <= tok_next;
      if (state == IDLE) begin
        state <= enable ? RUN : IDLE;
      end else if (!enable && state == DRAIN && mca_start && tok_next == '0) begin
        state <= IDLE;
        epoch <= '0;
      end else begin
        state <= enable ? RUN : DRAIN;
        epoch <= epoch_next;
      end
    end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sample_out <= '0;
      sample_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        sample_out <= sample_in;
        sample_valid <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
      overrun <= overrun_set || (overrun && !clear_overrun);
    end
endmodule

// File: tb/tb_mca_sequencer.sv
// tb_mca_sequencer: randomized scoreboard bench for mca_sequencer against a frame-list reference model
module tb_mca_sequencer;
  localparam int W = 32;
  localparam int NA = 4;
  localparam int NS = 3;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable = 1'b0;
  logic frame_valid = 1'b0;
  logic sample_ready = 1'b0;
  logic clear_overrun = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic frame_ready, mca_start, sample_valid, overrun, busy;
  logic [W-1:0] sample_out;
  int vectors = 0;
  int miscompares = 0;
  int mode = 0;
  int phase = 0;
  int fl[$];
  logic [W-1:0] sq[$];
  logic m_ov = 1'b0;
  logic exp_start = 1'b0;
  logic exp_fr = 1'b0;
  logic exp_busy = 1'b0;
  logic exp_valid = 1'b0;
  logic exp_overrun = 1'b0;
  mca_sequencer #(.WIDTH_COEFFICIENT(W), .NUM_ADDITIONS(NA), .NUM_STAGES(NS)) dut (
    .clk(clk),
    .resetn(resetn),
    .enable(enable),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .mca_start(mca_start),
    .sample_in(sample_in),
    .sample_out(sample_out),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .overrun(overrun),
    .clear_overrun(clear_overrun),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    vectors++;
    if (mca_start !== exp_start || frame_ready !== exp_fr || busy !== exp_busy ||
        sample_valid !== exp_valid || overrun !== exp_overrun) begin
      miscompares++;
      $display("FAIL ctrl t=%0t got start=%b ready=%b busy=%b valid=%b ovr=%b want %b %b %b %b %b",
               $time, mca_start, frame_ready, busy, sample_valid, overrun,
               exp_start, exp_fr, exp_busy, exp_valid, exp_overrun);
    end
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      vectors++;
      if (sq.size() == 0) begin
        miscompares++;
        $display("FAIL sample t=%0t got %h with no expected sample pending", $time, sample_out);
      end else begin
        logic [W-1:0] e;
        e = sq.pop_front();
        if (sample_out !== e) begin
          miscompares++;
          $display("FAIL sample t=%0t got %h want %h", $time, sample_out, e);
        end
      end
    end
  end
  // Model: mode 0 idle / 1 run / 2 drain, phase = cycle within epoch,
  // fl = starts remaining before each in-flight frame reaches the output.
  task automatic cycle(input logic en, input logic fv, input logic sr, input logic co);
    logic cap, set;
    @(posedge clk);
    #1;
    enable = en;
    frame_valid = fv;
    sample_ready = sr;
    clear_overrun = co;
    sample_in = $urandom;
    exp_busy = mode != 0;
    exp_start = mode != 0 && phase == 0;
    exp_fr = mode == 1 && phase == 0;
    exp_valid = sq.size() != 0;
    exp_overrun = m_ov;
    set = 1'b0;
    if (exp_start) begin
      cap = 1'b0;
      foreach (fl[i]) fl[i]--;
      if (fl.size() != 0 && fl[0] == 0) begin
        cap = 1'b1;
        void'(fl.pop_front());
      end
      if (exp_fr && fv) fl.push_back(NS);
      if (cap) begin
        if (exp_valid && !sr) begin
          set = 1'b1;
          void'(sq.pop_back());
        end
        sq.push_back(sample_in);
      end
    end
    m_ov = set ? 1'b1 : (co ? 1'b0 : m_ov);
    if (mode == 0) begin
      mode = en ? 1 : 0;
      phase = 0;
    end else if (!en && mode == 2 && exp_start && fl.size() == 0) begin
      mode = 0;
      phase = 0;
    end else begin
      mode = en ? 1 : 2;
      phase = (phase + 1) % NA;
    end
  endtask
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    resetn = 1'b0;
    enable = 1'b0;
    frame_valid = 1'b0;
    sample_ready = 1'b0;
    clear_overrun = 1'b0;
    #1;
    vectors++;
    if (mca_start !== 1'b0 || frame_ready !== 1'b0 || busy !== 1'b0 || sample_valid !== 1'b0 ||
        overrun !== 1'b0 || sample_out !== '0) begin
      miscompares++;
      $display("FAIL async_reset got start=%b ready=%b busy=%b valid=%b ovr=%b out=%h want all zero",
               mca_start, frame_ready, busy, sample_valid, overrun, sample_out);
    end
    mode = 0;
    phase = 0;
    fl.delete();
    sq.delete();
    m_ov = 1'b0;
    {exp_start, exp_fr, exp_busy, exp_valid, exp_overrun} = '0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    repeat (20) cycle(0, 0, 0, 0);
    repeat (60) cycle(1, 1, 1, 0);
    repeat (30) cycle(0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    cycle(1, 1, 1, 0);
    repeat (30) cycle(0, 0, 1, 0);
    repeat (40) cycle(1, 1, 0, 0);
    cycle(1, 0, 0, 1);
    repeat (20) cycle(1, 1, 1, 0);
    for (int i = 0; i < 1500; i++)
      cycle($urandom % 8 != 0, $urandom % 4 != 0, $urandom % 2 == 0, $urandom % 16 == 0);
    repeat (20) cycle(0, 0, 1, 0);
    repeat (20) cycle(1, 1, 1, 0);
    pulse_reset();
    repeat (30) cycle(1, 1, 1, 0);
    pulse_reset();
    repeat (10) cycle(0, 0, 1, 0);
    repeat (20) cycle(1, 1, 1, 0);
    repeat (30) cycle(0, 0, 1, 0);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
